// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the controller link
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_CLKS_PER_BIT = 95;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable 16-bit down counter with a zero flag
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] count_q;

  // Holds at zero until the next load so a stale zero never wraps around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && count_q != 16'd0) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign zero = (count_q == 16'd0);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and a valid/ready holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic sync1_q, rxs, rxs_d_q;
  logic fall;

  uart_rx_state_t state_q, next_state;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;

  logic        timer_load, timer_zero;
  logic [15:0] timer_val;
  logic        sample_bit, clr_idx, deliver, stop_bad;
  logic        handshake;

  // Both synchronizer flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
      rxs_d_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs     <= sync1_q;
      rxs_d_q <= rxs;
    end
  end

  assign fall = rxs_d_q && !rxs;

  uart_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (state_q != IDLE),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    timer_load = 1'b0;
    timer_val  = BIT_M1;
    sample_bit = 1'b0;
    clr_idx    = 1'b0;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          next_state = START;
          timer_load = 1'b1;
          timer_val  = HALF_M1;
        end
      end
      START: begin
        if (timer_zero) begin
          if (rxs) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
            timer_load = 1'b1;
            clr_idx    = 1'b1;
          end
        end
      end
      DATA: begin
        if (timer_zero) begin
          sample_bit = 1'b1;
          timer_load = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (timer_zero) begin
          next_state = IDLE;
          deliver    = rxs;
          stop_bad   = !rxs;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
    end else begin
      if (clr_idx) begin
        bit_idx_q <= 3'd0;
      end else if (sample_bit) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        shift_q[bit_idx_q] <= rxs;
      end
    end
  end

  assign handshake = rx_valid && rx_ready;

  // A byte arriving on the same cycle the consumer takes the old one replaces it without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || handshake) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 95 clocks per bit
module tb_uart_rx;

  localparam int CPB = 95;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_valid_cyc = 0;
  int t_valid_rise = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] last_data = 8'h00;

  int t0, f0, o0, v0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun)   n_ovr  <= n_ovr + 1;
    if (rx_valid) begin
      n_valid_cyc <= n_valid_cyc + 1;
      last_data   <= rx_data;
      if (!valid_prev) t_valid_rise <= cyc;
    end
    valid_prev <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start bit begins immediately.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(20);

    // single frame, latency from pin edge
    v0 = n_valid_cyc;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(30);
    check("a5_data", {24'd0, last_data}, 32'hA5);
    check("a5_valid_cycles", n_valid_cyc - v0, 32'd1);
    check("a5_latency", {31'd0, (t_valid_rise - t0 >= 900) && (t_valid_rise - t0 <= 906)}, 32'd1);
    check("a5_valid_after", {31'd0, rx_valid}, 32'd0);

    // glitch shorter than half a bit
    f0 = n_ferr; o0 = n_ovr; v0 = n_valid_cyc;
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(3 * CPB);
    check("glitch_valid", n_valid_cyc - v0, 32'd0);
    check("glitch_ferr", n_ferr - f0, 32'd0);
    check("glitch_ovr", n_ovr - o0, 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(30);
    check("3c_data", {24'd0, last_data}, 32'h3C);

    // framing error then recovery
    f0 = n_ferr; v0 = n_valid_cyc;
    send_frame(8'hFF, 1'b0);
    idle(2 * CPB);
    check("ferr_count", n_ferr - f0, 32'd1);
    check("ferr_valid", n_valid_cyc - v0, 32'd0);
    send_frame(8'h01, 1'b1);
    idle(30);
    check("01_data", {24'd0, last_data}, 32'h01);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    o0 = n_ovr; f0 = n_ferr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(30);
    check("ovr_data", {24'd0, rx_data}, 32'h11);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_count", n_ovr - o0, 32'd1);
    check("ovr_no_ferr", n_ferr - f0, 32'd0);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    idle(1);
    check("ovr_cleared", {31'd0, rx_valid}, 32'd0);

    // handshake exactly on the delivery cycle
    send_frame(8'h11, 1'b1);
    idle(30);
    check("sim_first", {24'd0, rx_data}, 32'h11);
    o0 = n_ovr;
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(904);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(30);
    check("sim_data", {24'd0, rx_data}, 32'h22);
    check("sim_valid", {31'd0, rx_valid}, 32'd1);
    check("sim_no_ovr", n_ovr - o0, 32'd0);
    rx_ready = 1'b1;
    idle(5);

    // reset during data bit 4 of 8'hC3
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hC3 >> i);
      idle(CPB);
    end
    rx = 1'b0;
    idle(40);
    rst = 1'b1;
    idle(3);
    check("mid_rst_data", {24'd0, rx_data}, 32'h00);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    rx = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2 * CPB);
    f0 = n_ferr;
    send_frame(8'h5A, 1'b1);
    idle(30);
    check("5a_data", {24'd0, last_data}, 32'h5A);
    check("5a_no_ferr", n_ferr - f0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
